fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage: holds the PC, issues word requests to a variable-latency instruction memory, buffers returned instructions in a small in-order queue and presents them to decode as `instr_D`/`pc_D`/`pcPlus4_D` with a valid flag. Redirects from execute (taken branch, `jal`, `jalr`) flush all buffered and in-flight instructions and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional response bypass to decode is enabled with FETCH_BYPASS_EN.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response channel.
// Master side is the fetch stage, slave side is the memory.
interface fetch_if #(
  parameter int WIDTH = 32
) ();

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular in-order FIFO of fetched instructions.
// Clear empties it in one cycle; head is shown combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem request issue, response queue, redirect flush.
// FETCH_BYPASS_EN lets a response reach decode in its arrival cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_if.master          imem,
  input  logic             redirect_E,
  input  logic [WIDTH-1:0] target_E,
  input  logic             stall_D,
  output logic             valid_D,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] pc_D,
  output logic [WIDTH-1:0] pcPlus4_D
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] tgt;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    inflight_nx;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;
  logic             accept;
  logic             rsp;
  logic             drop;
  logic             keep;
  logic             byp;
  logic             q_valid;
  logic             q_push;
  logic             q_pop;
  entry_t           q_din;
  entry_t           q_head;
  logic [WIDTH-1:0] cur_instr;
  logic [WIDTH-1:0] cur_pc;

  assign tgt    = {target_E[WIDTH-1:2], 2'b00};
  assign occ    = {1'b0, count} + {1'b0, inflight};
  assign imem.imem_req  = !rst && !redirect_E && (occ < LIMIT);
  assign imem.imem_addr = pc;

  assign accept = imem.imem_req && imem.imem_ready;
  assign rsp    = imem.imem_rvalid && (inflight != '0);
  assign drop   = discard != '0;
  // A response landing in a redirect cycle is stale by definition.
  assign keep   = rsp && !drop && !redirect_E;

  assign q_valid = count != '0;

`ifdef FETCH_BYPASS_EN
  assign byp = keep && !q_valid;
`else
  assign byp = 1'b0;
`endif

  assign q_pop  = q_valid && !stall_D;
  assign q_push = keep && !(byp && !stall_D);
  assign q_din  = '{instr: imem.imem_rdata, pc: rsp_pc};

  assign cur_instr = q_valid ? q_head.instr : imem.imem_rdata;
  assign cur_pc    = q_valid ? q_head.pc : rsp_pc;

  assign valid_D   = q_valid || byp;
  assign instr_D   = valid_D ? cur_instr : WIDTH'(NOP_INSTR);
  assign pc_D      = valid_D ? cur_pc : '0;
  assign pcPlus4_D = valid_D ? cur_pc + WIDTH'(4) : '0;

  assign inflight_nx = inflight + CW'(accept) - CW'(rsp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nx;
      if (redirect_E) begin
        pc      <= tgt;
        rsp_pc  <= tgt;
        discard <= inflight_nx;
      end else begin
        if (accept)      pc      <= pc + WIDTH'(4);
        if (rsp && drop) discard <= discard - 1'b1;
        if (keep)        rsp_pc  <= rsp_pc + WIDTH'(4);
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_E),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .head  (q_head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order memory model.
// Directed sequences cover start-up, stall, redirect, wrap and reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_E;
  logic [31:0] target_E;
  logic        stall_D;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pcPlus4_D;

  fetch_if #(.WIDTH(32)) bus ();

  fetch_unit #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus),
    .redirect_E (redirect_E),
    .target_E   (target_E),
    .stall_D    (stall_D),
    .valid_D    (valid_D),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .pcPlus4_D  (pcPlus4_D)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Memory: random ready, random per-request latency, strictly in order.
  int lat_min = 1;
  int lat_max = 1;
  int rdy_pct = 100;
  int cyc     = 0;

  initial begin
    logic [31:0] p_addr [$];
    int          p_due  [$];
    int          last_due;
    int          d;
    last_due = 0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        p_addr.delete();
        p_due.delete();
        last_due = 0;
        bus.imem_rvalid = 1'b0;
      end else if (p_due.size() > 0 && p_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(p_addr.pop_front());
        void'(p_due.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
      bus.imem_ready = (rdy_pct >= 100) ||
                       ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (!rst && bus.imem_req && bus.imem_ready) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        p_addr.push_back(bus.imem_addr);
        p_due.push_back(d);
      end
    end
  end

  // Scoreboard: decode must see the sequential stream since the last
  // reset or redirect target.
  initial begin
    logic [31:0] expq [$];
    logic [31:0] gen_pc;
    gen_pc = RST_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        gen_pc = RST_PC;
      end else begin
        if (valid_D) begin
          chk("instr_D", instr_D, mem_word(expq[0]));
          chk("pc_D", pc_D, expq[0]);
          chk("pcPlus4_D", pcPlus4_D, expq[0] + 32'd4);
          if (!stall_D) begin
            void'(expq.pop_front());
            n_pop++;
          end
        end else begin
          chk("idle_instr", instr_D, NOP_INSTR);
          chk("idle_pc", pc_D, 32'h0);
          chk("idle_pc4", pcPlus4_D, 32'h0);
        end
        if (redirect_E) begin
          expq.delete();
          gen_pc = {target_E[31:2], 2'b00};
        end
      end
      while (expq.size() < 8) begin
        expq.push_back(gen_pc);
        gen_pc += 32'd4;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          start;
    logic        found;
    logic [31:0] a;
    rst        = 1'b1;
    redirect_E = 1'b0;
    target_E   = '0;
    stall_D    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", valid_D, 1'b0);
    chk("rst_instr", instr_D, NOP_INSTR);
    chk("rst_pc", pc_D, 32'h0);
    chk("rst_pc4", pcPlus4_D, 32'h0);
    next_cyc();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("seq_req", bus.imem_req, 1'b1);
      chk("seq_addr", bus.imem_addr, 32'(4 * i));
      if (i < 2 - BYP) chk("seq_early", valid_D, 1'b0);
      else chk("seq_pc", pc_D, 32'(4 * (i - 2 + BYP)));
      next_cyc();
    end

    stall_D = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("stall_req", bus.imem_req, 1'b0);
        chk("stall_valid", valid_D, 1'b1);
      end
      next_cyc();
    end
    stall_D = 1'b0;

    lat_min = 2;
    lat_max = 2;
    repeat (8) next_cyc();
    redirect_E = 1'b1;
    target_E   = 32'h0000_0102;
    @(negedge clk);
    chk("redir_req", bus.imem_req, 1'b0);
    next_cyc();
    redirect_E = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("redir_req1", bus.imem_req, 1'b1);
        chk("redir_addr", bus.imem_addr, 32'h0000_0100);
      end
      if (k < 4 - BYP) begin
        chk("redir_stale", valid_D, 1'b0);
      end else begin
        chk("redir_first", valid_D, 1'b1);
        chk("redir_pc", pc_D, 32'h0000_0100);
      end
      next_cyc();
    end

    lat_min = 1;
    lat_max = 1;
    repeat (6) next_cyc();
    stall_D = 1'b1;
    next_cyc();
    stall_D    = 1'b0;
    redirect_E = 1'b1;
    target_E   = 32'h0000_0200;
    @(negedge clk);
    chk("coin_valid", valid_D, 1'b1);
    next_cyc();
    redirect_E = 1'b0;
    @(negedge clk);
    chk("coin_empty", valid_D, 1'b0);
    next_cyc();

    redirect_E = 1'b1;
    target_E   = 32'hFFFF_FFF8;
    next_cyc();
    redirect_E = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 32'hFFFF_FFF8 + 32'(4 * k);
      chk("wrap_req", bus.imem_req, 1'b1);
      chk("wrap_addr", bus.imem_addr, a);
      next_cyc();
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (valid_D && pc_D == 32'hFFFF_FFFC) begin
        found = 1'b1;
        chk("wrap_pc4", pcPlus4_D, 32'h0);
      end
      next_cyc();
    end
    chk("wrap_seen", found, 1'b1);

    lat_min = 3;
    lat_max = 3;
    stall_D = 1'b1;
    repeat (6) next_cyc();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus.imem_req, 1'b0);
    chk("arst_valid", valid_D, 1'b0);
    chk("arst_instr", instr_D, NOP_INSTR);
    chk("arst_pc", pc_D, 32'h0);
    chk("arst_pc4", pcPlus4_D, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    stall_D = 1'b0;
    lat_min = 1;
    lat_max = 1;
    @(negedge clk);
    chk("restart_req", bus.imem_req, 1'b1);
    chk("restart_addr", bus.imem_addr, RST_PC);
    next_cyc();

    rdy_pct = 70;
    lat_max = 4;
    start   = n_pop;
    repeat (600) begin
      stall_D    = $urandom_range(99) < 30;
      redirect_E = $urandom_range(99) < 4;
      target_E   = $urandom & 32'h0000_3FFF;
      @(negedge clk);
      if (redirect_E) chk("rnd_redir_req", bus.imem_req, 1'b0);
      if (bus.imem_req) chk("rnd_align", bus.imem_addr[1:0], 2'b00);
      next_cyc();
    end
    stall_D    = 1'b0;
    redirect_E = 1'b0;
    rdy_pct    = 100;
    repeat (30) next_cyc();
    chk("rnd_progress", n_pop > start + 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
